// File: rtl/weight_load_ctrl_pkg.sv
// Kernel-set geometry and controller state encodings shared by the weight RAM and the compute controller.
package weight_load_ctrl_pkg;

  localparam int WL_NUM_W = 3 * 3 * 3 * 2;
  localparam int WL_DW    = 8;
  localparam int WL_CNT_W = $clog2(WL_NUM_W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

endpackage

// File: rtl/weight_load_ctrl.sv
// Streams one kernel set into the shift-in weight RAM and flags it valid for compute.
// Latency: accepted byte appears on ram_wen/ram_din one cycle later; load_done/w_valid align with the final write.
// Backpressure: s_ready is high only in LOAD; reloads wait in FULL while comp_busy is high.
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int NUM_W = WL_NUM_W,
  parameter int DW    = WL_DW,
  parameter int CNT_W = WL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [DW-1:0]    s_data,
  output logic             s_ready,
  output logic             ram_wen,
  output logic [DW-1:0]    ram_din,
  input  logic             comp_busy,
  output logic             w_valid,
  output logic             load_done,
  output logic             loading,
  output logic [CNT_W-1:0] fill_cnt,
  output logic             load_pend
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_W - 1);
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(NUM_W);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_ram_wen;
  logic [DW-1:0]    r_ram_din;
  logic             r_w_valid;
  logic             r_load_done;
  logic [CNT_W-1:0] r_fill_cnt;
  logic             r_load_pend;
  logic             w_in_load;
  logic             w_accept;
  logic             w_start;
  logic             w_complete;
  logic             w_abort;

  assign w_in_load = (r_state == ST_LOAD);
  assign w_accept  = s_valid & w_in_load;
  assign w_abort   = w_in_load & abort;
  // Abort beats a simultaneous final byte: the set is never declared complete.
  assign w_complete = w_accept & ~abort & (r_fill_cnt == LP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_req) begin
          w_state_nxt = ST_LOAD;
          w_start     = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_complete) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (!comp_busy && (load_req || r_load_pend)) begin
          w_state_nxt = ST_LOAD;
          w_start     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ram_wen   <= 1'b0;
      r_ram_din   <= '0;
      r_w_valid   <= 1'b0;
      r_load_done <= 1'b0;
      r_fill_cnt  <= '0;
      r_load_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ram_wen   <= w_accept;
      r_load_done <= w_complete;
      if (w_accept) begin
        r_ram_din <= s_data;
      end

      if (w_start) begin
        r_w_valid <= 1'b0;
      end else if (w_complete) begin
        r_w_valid <= 1'b1;
      end

      if (w_start || w_abort) begin
        r_fill_cnt <= '0;
      end else if (w_accept && (r_fill_cnt < LP_FULL)) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
      end

      // A reload requested while compute holds the weights is parked until it lets go.
      if (w_start) begin
        r_load_pend <= 1'b0;
      end else if ((r_state == ST_FULL) && load_req && comp_busy) begin
        r_load_pend <= 1'b1;
      end
    end
  end

  assign s_ready   = w_in_load;
  assign loading   = w_in_load;
  assign ram_wen   = r_ram_wen;
  assign ram_din   = r_ram_din;
  assign w_valid   = r_w_valid;
  assign load_done = r_load_done;
  assign fill_cnt  = r_fill_cnt;
  assign load_pend = r_load_pend;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: driver queues expected RAM writes, a negedge monitor retires them.
module tb_weight_load_ctrl;
  import weight_load_ctrl_pkg::*;

  localparam int NUM_W = WL_NUM_W;
  localparam int DW    = WL_DW;
  localparam int CNT_W = WL_CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_req = 1'b0;
  logic             abort = 1'b0;
  logic             s_valid = 1'b0;
  logic [DW-1:0]    s_data = '0;
  logic             s_ready;
  logic             ram_wen;
  logic [DW-1:0]    ram_din;
  logic             comp_busy = 1'b0;
  logic             w_valid;
  logic             load_done;
  logic             loading;
  logic [CNT_W-1:0] fill_cnt;
  logic             load_pend;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int done_base;
  logic [DW-1:0] sb[$];

  weight_load_ctrl #(.NUM_W(NUM_W), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ram_wen(ram_wen), .ram_din(ram_din), .comp_busy(comp_busy),
    .w_valid(w_valid), .load_done(load_done), .loading(loading),
    .fill_cnt(fill_cnt), .load_pend(load_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Drive one byte the DUT must take this cycle and queue its expected write.
  task automatic send(input int d);
    s_valid = 1'b1;
    s_data  = DW'(d);
    check("s_ready_in_load", int'(s_ready), 1);
    sb.push_back(DW'(d));
    tick();
    s_valid = 1'b0;
  endtask

  // Monitor: every RAM write must match the oldest queued byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_wen) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got din=%0d expected no write", ram_din);
        end else begin
          check("ram_din", int'(ram_din), int'(sb.pop_front()));
        end
      end
      if (load_done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_ram_wen", int'(ram_wen), 0);
    check("rst_ram_din", int'(ram_din), 0);
    check("rst_w_valid", int'(w_valid), 0);
    check("rst_load_done", int'(load_done), 0);
    check("rst_loading", int'(loading), 0);
    check("rst_fill_cnt", int'(fill_cnt), 0);
    check("rst_load_pend", int'(load_pend), 0);
    #10 rst_n = 1'b1;
    tick();

    // abort in IDLE is ignored
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle_abort_loading", int'(loading), 0);

    // 1: back-to-back load of 0..53
    done_base = done_cnt;
    pulse_req();
    check("t1_loading", int'(loading), 1);
    check("t1_fill0", int'(fill_cnt), 0);
    check("t1_wvalid0", int'(w_valid), 0);
    for (int i = 0; i < NUM_W; i++) begin
      s_valid = 1'b1; s_data = DW'(i); sb.push_back(DW'(i)); tick();
    end
    s_valid = 1'b0;
    check("t1_full_s_ready", int'(s_ready), 0);
    check("t1_done_pulse", int'(load_done), 1);
    check("t1_w_valid", int'(w_valid), 1);
    check("t1_fill_full", int'(fill_cnt), NUM_W);
    check("t1_last_wen", int'(ram_wen), 1);
    tick();
    check("t1_done_low", int'(load_done), 0);
    check("t1_done_count", done_cnt - done_base, 1);
    check("t1_sb_empty", sb.size(), 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("full_abort_w_valid", int'(w_valid), 1);
    check("full_abort_fill", int'(fill_cnt), NUM_W);

    // 2: reload with s_valid toggling; extra byte in FULL must be refused
    done_base = done_cnt;
    pulse_req();
    check("t2_w_valid_cleared", int'(w_valid), 0);
    for (int i = 0; i < NUM_W; i++) begin
      check("t2_fill_step", int'(fill_cnt), i);
      send(100 + i);
      tick();
    end
    check("t2_fill_full", int'(fill_cnt), NUM_W);
    s_valid = 1'b1; s_data = 8'hEE;
    check("t2_full_s_ready", int'(s_ready), 0);
    tick(); tick();
    s_valid = 1'b0;
    check("t2_fill_sat", int'(fill_cnt), NUM_W);
    check("t2_done_count", done_cnt - done_base, 1);

    // 3: deferred reload while compute is busy
    comp_busy = 1'b1;
    pulse_req();
    check("t3_pend", int'(load_pend), 1);
    check("t3_w_valid_held", int'(w_valid), 1);
    check("t3_not_loading", int'(loading), 0);
    tick();
    check("t3_still_full", int'(loading), 0);
    comp_busy = 1'b0;
    tick();
    check("t3_loading", int'(loading), 1);
    check("t3_w_valid0", int'(w_valid), 0);
    check("t3_pend_clr", int'(load_pend), 0);

    // 4: abort after 20 bytes, then reload with a stray load_req at byte 10
    done_base = done_cnt;
    for (int i = 0; i < 20; i++) send(200 + i);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t4_idle", int'(loading), 0);
    check("t4_fill0", int'(fill_cnt), 0);
    check("t4_w_valid0", int'(w_valid), 0);
    tick();
    check("t4_no_done", done_cnt - done_base, 0);
    pulse_req();
    for (int i = 0; i < NUM_W; i++) begin
      if (i == 10) load_req = 1'b1;
      send(i ^ 8'h5A);
      load_req = 1'b0;
    end
    check("t4_fill_full", int'(fill_cnt), NUM_W);
    check("t4_w_valid", int'(w_valid), 1);
    tick();
    check("t4_single_done", done_cnt - done_base, 1);
    check("t4_no_pend", int'(load_pend), 0);

    // 5: abort together with the final byte
    done_base = done_cnt;
    pulse_req();
    for (int i = 0; i < NUM_W - 1; i++) send(i + 3);
    abort = 1'b1;
    send(77);
    abort = 1'b0;
    check("t5_idle", int'(loading), 0);
    check("t5_no_done_pulse", int'(load_done), 0);
    check("t5_w_valid0", int'(w_valid), 0);
    check("t5_fill0", int'(fill_cnt), 0);
    tick();
    check("t5_no_done", done_cnt - done_base, 0);

    // 6: asynchronous reset at byte 30
    pulse_req();
    for (int i = 0; i < 29; i++) send(i);
    s_valid = 1'b1; s_data = 8'd29; sb.push_back(8'd29);
    tick();
    s_valid = 1'b1; s_data = 8'd30;
    #2 rst_n = 1'b0;
    #1;
    check("t6_s_ready", int'(s_ready), 0);
    check("t6_ram_wen", int'(ram_wen), 0);
    check("t6_ram_din", int'(ram_din), 0);
    check("t6_loading", int'(loading), 0);
    check("t6_fill", int'(fill_cnt), 0);
    check("t6_w_valid", int'(w_valid), 0);
    check("t6_done", int'(load_done), 0);
    check("t6_pend", int'(load_pend), 0);
    s_valid = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_idle", int'(loading), 0);
    pulse_req();
    check("t6_idle_to_load", int'(loading), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    tick();
    check("end_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_load_ctrl.md
Name: weight_load_ctrl

Overview:
Sequences loading of one full kernel set (3x3x3x2 = 54 bytes) into the shift-in weight RAM from an upstream byte stream using a valid/ready handshake. Tracks the fill count and publishes a weights-valid flag to the conv compute engine. Defers a reload request until compute releases the current weights. Sits between the host/DMA byte stream and the weight RAM write port (wen/din).

Parameters:
NUM_W, 54, bytes per kernel set (RAM depth); must match RAM depth
DW, 8, weight byte width
CNT_W, 6, fill-counter width; ceil(log2(NUM_W+1))

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_req  input  1  1-cycle pulse: request a fresh kernel load
abort  input  1  1-cycle pulse: cancel an in-progress load
s_valid  input  1  upstream byte valid
s_data  input  DW  upstream weight byte
s_ready  output  1  controller accepts a byte this cycle
ram_wen  output  1  weight RAM shift-in enable (registered)
ram_din  output  DW  weight RAM data (registered)
comp_busy  input  1  compute engine is reading weights; reload must wait
w_valid  output  1  RAM holds a complete, coherent kernel set
load_done  output  1  1-cycle pulse when the final byte has been written
loading  output  1  high while in LOAD
fill_cnt  output  CNT_W  bytes accepted in the current load
load_pend  output  1  a deferred load_req is latched

Behaviour:
- Reset (async, rst_n=0): state=IDLE; s_ready=0, ram_wen=0, ram_din=0, w_valid=0, load_done=0, loading=0, fill_cnt=0, load_pend=0.
- States: IDLE, LOAD, FULL.
- IDLE: load_req -> LOAD, fill_cnt=0.
- LOAD: s_ready=1 (combinational from state; not qualified by s_valid). On accept (s_valid & s_ready): next cycle ram_wen=1, ram_din=s_data, fill_cnt+1. No accept -> ram_wen=0 next cycle; bubbles allowed indefinitely.
- Accept of byte NUM_W (fill_cnt==NUM_W-1 at accept) -> FULL. On the following edge, together with the final ram_wen, load_done pulses 1 cycle and w_valid rises. s_ready is 0 in the FULL cycle, so no extra byte is ever accepted.
- Entering LOAD from any state drives w_valid=0 on the same edge; the RAM is being overwritten.
- abort in LOAD -> IDLE, fill_cnt=0, w_valid stays 0. A byte accepted in the abort cycle is still written, so ram_wen may be 1 one cycle after abort. abort in IDLE/FULL is ignored.
- FULL: w_valid=1 held. load_req with comp_busy=0 -> LOAD. load_req with comp_busy=1 -> load_pend=1, remain FULL. When comp_busy=0 and load_pend=1 -> LOAD, load_pend cleared on the same edge.
- load_req in LOAD is ignored (not latched). Simultaneous load_req and abort in LOAD: abort wins -> IDLE.
- Simultaneous final-byte accept and abort: abort wins -> IDLE, no load_done, w_valid=0.
- loading = (state==LOAD).
- fill_cnt saturates at NUM_W and never wraps. It holds NUM_W in FULL and clears on entry to LOAD.
- Reset mid-load: all outputs return to reset values immediately. RAM contents are undefined and w_valid=0 protects consumers.

Decomposition:
- Shared package/header: NUM_W (3*3*3*2), DW, CNT_W, state encodings IDLE=2'd0, LOAD=2'd1, FULL=2'd2. The weight RAM and the compute controller share these.
- No sub-module needed; a single FSM plus counter. An optional integration wrapper weight_load_top instantiates this block with weight_ram.

Test Plan:
- Reset, load_req, then 54 back-to-back bytes 0..53 -> 54 ram_wen pulses with ram_din 0..53 (1-cycle lag); load_done pulse once; w_valid=1; through weight_ram, dout byte i = i.
- Same load with s_valid toggling every other cycle -> still exactly 54 writes; fill_cnt steps 0..54; s_ready never 1 in FULL.
- abort after 20 bytes -> IDLE, fill_cnt=0, w_valid=0, no load_done; then a full reload succeeds.
- In FULL, comp_busy=1 and load_req -> load_pend=1, w_valid stays 1; comp_busy falls -> next cycle LOAD, w_valid=0, load_pend=0.
- rst_n asserted at byte 30 -> all outputs 0 asynchronously (before the next clk edge); after release the state is IDLE.
- load_req during LOAD at byte 10 -> ignored; load completes at 54 with a single load_done.
